// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared constants and types for the Pong ball datapath.
//   - Screen and object geometry (all 11-bit so sums never wrap).
//   - Ball centre coordinates used for reset and serve.
//   - Ball FSM state encoding and the left/right side type.
//   - step_axis(): one clamped BALL_V step along a single axis.
// No ports; imported by ball_motion and paddle_hit.
// -----------------------------------------------------------------------------
package pong_pkg;

  // Geometry is held 11 bits wide: the largest sum formed anywhere is a
  // 10-bit paddle y plus PADDLE_H, which still fits with no wrap.
  localparam logic [10:0] H_MAX      = 11'd640;
  localparam logic [10:0] V_MAX      = 11'd480;
  localparam logic [10:0] BALL_SIZE  = 11'd8;
  localparam logic [10:0] BALL_V     = 11'd2;
  localparam logic [10:0] PADDLE_W   = 11'd4;
  localparam logic [10:0] PADDLE_H   = 11'd72;
  localparam logic [10:0] L_PADDLE_X = 11'd32;
  localparam logic [10:0] R_PADDLE_X = 11'd600;

  // Largest legal left/top edge of the ball.
  localparam logic [10:0] X_LIMIT = H_MAX - BALL_SIZE;
  localparam logic [10:0] Y_LIMIT = V_MAX - BALL_SIZE;

  // Centre of the play field for the ball's top-left corner (316, 236).
  localparam logic [9:0] CENTRE_X = X_LIMIT[10:1];
  localparam logic [9:0] CENTRE_Y = Y_LIMIT[10:1];

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,  // parked at centre while the game FSM asserts restart
    ST_MOVE = 2'd1,  // advancing once per frame tick
    ST_DEAD = 2'd2   // ball has left the field; frozen until restart
  } state_t;

  // Used both for paddle identity and for horizontal travel direction.
  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_t;

  // One step of BALL_V along an axis, clamped to [0, lim]. The backwards
  // case tests pos < BALL_V before subtracting so the result cannot wrap.
  function automatic logic [10:0] step_axis(
    input logic [10:0] pos,
    input logic        fwd,
    input logic [10:0] lim
  );
    logic [10:0] result;
    if (fwd) begin
      result = ((pos + BALL_V) > lim) ? lim : (pos + BALL_V);
    end else begin
      result = (pos < BALL_V) ? 11'd0 : (pos - BALL_V);
    end
    return result;
  endfunction

endpackage : pong_pkg

// File: rtl/ball_motion_paddle_hit.sv
// -----------------------------------------------------------------------------
// paddle_hit
// Purely combinational contact test between the ball's next position and one
// paddle. The horizontal window depends on which side the paddle guards:
// the right paddle is met by the ball's right edge, the left paddle by its
// left edge. Travel direction is not checked here; the caller gates the
// result with it.
// Ports:
//   i_nx, i_ny : next ball left/top edge
//   i_px, i_py : paddle left/top edge
//   i_side     : which paddle this instance models
//   o_hit      : ball overlaps the paddle on both axes
// -----------------------------------------------------------------------------
module paddle_hit
  import pong_pkg::*;
(
  input  logic [10:0] i_nx,
  input  logic [10:0] i_ny,
  input  logic [10:0] i_px,
  input  logic [10:0] i_py,
  input  side_t       i_side,
  output logic        o_hit
);

  logic w_ovl;
  logic w_x_right;
  logic w_x_left;

  // Strict '>' / '<' : a ball merely touching the paddle's top or bottom
  // edge does not count as a hit.
  assign w_ovl = ((i_ny + BALL_SIZE) > i_py) && (i_ny < (i_py + PADDLE_H));

  // Right paddle: ball's right edge has reached the paddle face and the
  // ball has not yet passed the paddle's far edge.
  assign w_x_right = ((i_nx + BALL_SIZE) >= i_px) && (i_nx <= (i_px + PADDLE_W));

  // Left paddle: mirror image, measured from the ball's left edge.
  assign w_x_left = (i_nx <= (i_px + PADDLE_W)) && ((i_nx + BALL_SIZE) > i_px);

  assign o_hit = w_ovl && ((i_side == SIDE_RIGHT) ? w_x_right : w_x_left);

endmodule : paddle_hit

// File: rtl/ball_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
// Owns the Pong ball: position, direction and the HOLD/MOVE/DEAD sequencing.
// On each endofframe tick in MOVE the ball steps BALL_V on both axes,
// bounces off the top/bottom walls and both paddles, and reports paddle
// hits and misses as one-cycle pulses for the game-control FSM. The FSM's
// restart level parks the ball at centre from any state.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   endofframe : one-cycle pulse per video frame (motion tick)
//   restart    : level from game FSM; 1 = hold ball at centre
//   left_y     : top y of left paddle
//   right_y    : top y of right paddle
//   ball_x     : ball left edge x (registered)
//   ball_y     : ball top edge y (registered)
//   collided   : bit0 left paddle hit, bit1 right paddle hit (pulse)
//   missed     : bit0 exited left, bit1 exited right (pulse)
// -----------------------------------------------------------------------------
module ball_motion
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       endofframe,
  input  logic       restart,
  input  logic [9:0] left_y,
  input  logic [9:0] right_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] collided,
  output logic [1:0] missed
);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [9:0] r_x;
  logic [9:0] r_y;
  side_t      r_dir_x;      // horizontal travel direction
  logic       r_dir_down;   // 1 = moving toward larger y
  side_t      r_miss_side;  // side that last missed; sets the next serve
  logic [1:0] r_collided;
  logic [1:0] r_missed;

  // Next-state values
  state_t     w_next_state;
  logic [9:0] w_next_x;
  logic [9:0] w_next_y;
  side_t      w_next_dir_x;
  logic       w_next_dir_down;
  side_t      w_next_miss_side;
  logic [1:0] w_next_collided;
  logic [1:0] w_next_missed;

  // ---------------------------------------------------------------------------
  // Candidate position for this tick, always derived from the current
  // registers so every event below sees the same nx/ny.
  // ---------------------------------------------------------------------------
  logic [10:0] w_nx;
  logic [10:0] w_ny;

  assign w_nx = step_axis({1'b0, r_x}, (r_dir_x == SIDE_RIGHT), X_LIMIT);
  assign w_ny = step_axis({1'b0, r_y}, r_dir_down, Y_LIMIT);

  // ---------------------------------------------------------------------------
  // Paddle contact tests
  // ---------------------------------------------------------------------------
  logic w_hit_left;
  logic w_hit_right;

  paddle_hit u_hit_left (
    .i_nx   (w_nx),
    .i_ny   (w_ny),
    .i_px   (L_PADDLE_X),
    .i_py   ({1'b0, left_y}),
    .i_side (SIDE_LEFT),
    .o_hit  (w_hit_left)
  );

  paddle_hit u_hit_right (
    .i_nx   (w_nx),
    .i_ny   (w_ny),
    .i_px   (R_PADDLE_X),
    .i_py   ({1'b0, right_y}),
    .i_side (SIDE_RIGHT),
    .o_hit  (w_hit_right)
  );

  // A paddle only counts when the ball is travelling toward it; otherwise a
  // ball that just bounced could be re-detected on its way out.
  logic w_bounce_left;
  logic w_bounce_right;

  assign w_bounce_right = w_hit_right && (r_dir_x == SIDE_RIGHT);
  assign w_bounce_left  = w_hit_left  && (r_dir_x == SIDE_LEFT);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would make synthesis infer a latch to remember it.
    w_next_state     = r_state;
    w_next_x         = r_x;
    w_next_y         = r_y;
    w_next_dir_x     = r_dir_x;
    w_next_dir_down  = r_dir_down;
    w_next_miss_side = r_miss_side;
    w_next_collided  = 2'b00;   // pulses fall back to zero every cycle
    w_next_missed    = 2'b00;

    if (restart) begin
      // restart wins over everything, including a coincident tick.
      w_next_state    = ST_HOLD;
      w_next_x        = CENTRE_X;
      w_next_y        = CENTRE_Y;
      w_next_dir_down = 1'b1;
      // Serve toward the player who just lost the point.
      if (r_state == ST_DEAD) begin
        w_next_dir_x = r_miss_side;
      end
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_next_x     = CENTRE_X;
          w_next_y     = CENTRE_Y;
          w_next_state = ST_MOVE;
        end

        ST_MOVE: begin
          if (endofframe) begin
            w_next_x = w_nx[9:0];
            w_next_y = w_ny[9:0];

            // Walls act on y only and may coincide with a paddle event.
            if (w_ny == 11'd0) begin
              w_next_dir_down = 1'b1;
            end else if (w_ny == Y_LIMIT) begin
              w_next_dir_down = 1'b0;
            end

            // Paddle hits take priority over a miss on the same tick.
            if (w_bounce_right) begin
              w_next_dir_x    = SIDE_LEFT;
              w_next_collided = 2'b10;
            end else if (w_bounce_left) begin
              w_next_dir_x    = SIDE_RIGHT;
              w_next_collided = 2'b01;
            end else if (w_nx == 11'd0) begin
              w_next_missed    = 2'b01;
              w_next_miss_side = SIDE_LEFT;
              w_next_state     = ST_DEAD;
            end else if (w_nx == X_LIMIT) begin
              w_next_missed    = 2'b10;
              w_next_miss_side = SIDE_RIGHT;
              w_next_state     = ST_DEAD;
            end
          end
        end

        ST_DEAD: begin
          // Frozen at the exit position; only restart leaves this state.
        end

        default: begin
          // Unused encoding: recover by parking the ball.
          w_next_state = ST_HOLD;
          w_next_x     = CENTRE_X;
          w_next_y     = CENTRE_Y;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_x         <= CENTRE_X;
      r_y         <= CENTRE_Y;
      r_dir_x     <= SIDE_RIGHT;
      r_dir_down  <= 1'b1;
      r_miss_side <= SIDE_RIGHT;
      r_collided  <= 2'b00;
      r_missed    <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples values
      // from before this edge, regardless of statement order.
      r_state     <= w_next_state;
      r_x         <= w_next_x;
      r_y         <= w_next_y;
      r_dir_x     <= w_next_dir_x;
      r_dir_down  <= w_next_dir_down;
      r_miss_side <= w_next_miss_side;
      r_collided  <= w_next_collided;
      r_missed    <= w_next_missed;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers
  // ---------------------------------------------------------------------------
  assign ball_x   = r_x;
  assign ball_y   = r_y;
  assign collided = r_collided;
  assign missed   = r_missed;

endmodule : ball_motion

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Upstream neighbour of the Pong game-control FSM.
- Owns ball position and direction, advances the ball once per frame tick, and bounces it off the top/bottom walls and both paddles.
- Produces the per-side `collided[1:0]` and `missed[1:0]` pulses that the FSM consumes.
- Obeys the FSM's `restart` level: while high, the ball is held at screen centre.

Parameters:
- H_MAX, 640, visible width in pixels
- V_MAX, 480, visible height in pixels
- BALL_SIZE, 8, ball square edge in pixels
- BALL_V, 2, pixels moved per axis per tick
- PADDLE_W, 4, paddle width in pixels
- PADDLE_H, 72, paddle height in pixels
- L_PADDLE_X, 32, left paddle left edge x
- R_PADDLE_X, 600, right paddle left edge x

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- endofframe  in  1  one-cycle pulse per video frame; the motion tick
- restart  in  1  from game FSM; level; 1 = hold ball at centre
- left_y  in  10  top y of left paddle
- right_y  in  10  top y of right paddle
- ball_x  out  10  ball left edge x, registered
- ball_y  out  10  ball top edge y, registered
- collided  out  2  bit0 = left paddle hit, bit1 = right paddle hit; one-cycle pulse
- missed  out  2  bit0 = ball exited left, bit1 = ball exited right; one-cycle pulse

Behaviour:
- Clock and reset: single clock `clk`; `reset` is asynchronous, active-high.
- Reset values:
  - ball_x = (H_MAX-BALL_SIZE)/2 = 316; ball_y = (V_MAX-BALL_SIZE)/2 = 236.
  - dir_x = right, dir_y = down.
  - collided = 0, missed = 0.
  - state = HOLD.
- States:
  - HOLD: ball at centre; pulses 0; endofframe ignored. restart=0 -> MOVE.
  - MOVE: updates only on an endofframe cycle. restart=1 -> HOLD. A miss -> DEAD.
  - DEAD: ball frozen at its exit position; no further pulses. restart=1 -> HOLD.
- restart=1 in any state: next clock the ball is at centre, state = HOLD, pulses cleared. This covers restart mid-motion.
- Tick update in MOVE, all computed from current registers, results registered, so outputs change 1 cycle after endofframe:
  - nx = x ± BALL_V, clamped to [0, H_MAX-BALL_SIZE]; ny likewise, clamped to [0, V_MAX-BALL_SIZE].
  - Subtraction checks x < BALL_V first, so there is no unsigned underflow.
- Wall:
  - ny == 0 -> dir_y = down.
  - ny == V_MAX-BALL_SIZE -> dir_y = up.
- Vertical overlap test (ovl(py)): ny+BALL_SIZE > py and ny < py+PADDLE_H.
- Right paddle hit (dir_x right only):
  - Condition: nx+BALL_SIZE >= R_PADDLE_X and nx <= R_PADDLE_X+PADDLE_W and ovl(right_y).
  - Action: dir_x = left; collided[1] = 1 for exactly one cycle.
- Left paddle hit (dir_x left only):
  - Condition: nx <= L_PADDLE_X+PADDLE_W and nx+BALL_SIZE > L_PADDLE_X and ovl(left_y).
  - Action: dir_x = right; collided[0] = 1 for one cycle.
- Miss:
  - nx == 0 -> missed[0] pulse, state DEAD.
  - nx == H_MAX-BALL_SIZE -> missed[1] pulse, state DEAD.
- Priority: paddle hit over miss in the same tick. Wall and paddle events in the same tick both apply, flipping both directions.
- Serve direction:
  - On entering HOLD after a miss, dir_x points toward the side that missed; dir_y = down.
  - After reset, dir_x = right.
- Pulses are never asserted in the same cycle for both bits of `missed`.

Decomposition:
- Package pong_pkg holds: H_MAX, V_MAX, BALL_SIZE, PADDLE_W, PADDLE_H, the paddle x constants, the centre coordinates, and the state encoding (HOLD/MOVE/DEAD, 2 bits).
- One combinational sub-module, paddle_hit:
  - Inputs: nx, ny, paddle x, paddle y, approach side.
  - Output: hit.
  - Instantiated twice, once per paddle.

Test Plan:
- Reset, then hold restart=1 with 5 ticks -> ball_x=316, ball_y=236, collided=0, missed=0 throughout.
- restart=0, 3 ticks, paddles at y=0 -> ball (322,242), each update 1 cycle after its tick.
- Continue to tick 118 -> ball_y=472, dir_y flips; tick 119 -> ball_y=470, no pulses.
- right_y=400, tick 138 -> ball_x=592, ball_y=432, collided=2'b10 for one cycle; tick 139 -> ball_x=590.
- Rerun with right_y=0 -> tick 158: ball_x=632, missed=2'b10 for one cycle; 10 further ticks leave ball frozen and missed=0. Then restart=1 -> (316,236), and first tick after restart=0 gives ball_x=318.
- Mid-flight restart=1 at tick 50 -> next clock ball (316,236), no pulse.
- endofframe and restart asserted together -> centre, no move.
